ref_fetch_scheduler: RTL and testbench
======================================

# ref_fetch_scheduler

Per-reader read scheduler that turns one "fetch N reference blocks from address A" command into a sequence of AXI-legal burst requests on one AXI arbiter port. It bounds in-flight data with a beat-credit counter and returns the data beats, in order, through a registered skid stage. One instance sits in front of each of the four reference reader ports of the AXI arbiter.

## Interface
Parameters:
- MAX_BURST, 16: maximum beats per burst; legal range 1..256.
- MAX_CREDIT, 64: maximum beats requested but not yet delivered on the blk interface; must be ≥ MAX_BURST.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- start_in  in  1  command strobe; accepted only in IDLE.
- base_addr_in  in  32  byte address of the first block; bits [4:0] ignored and treated as 0.
- num_blocks_in  in  32  number of 256-bit blocks to fetch.
- busy_out  out  1  high from accepted start until done.
- done_out  out  1  one-cycle pulse at completion.
- rd_id_out  out  6  burst ID.
- rd_addr_out  out  32  burst byte address.
- rd_len_out  out  8  burst length, encoded as beats−1.
- rd_info_valid_out  out  1  request valid.
- rd_info_rdy_in  in  1  request accepted.
- rd_data_in  in  256  returned beat.
- rd_data_valid_in  in  1  beat valid.
- rd_data_rdy_out  out  1  beat accepted.
- blk_data_out  out  256  delivered beat.
- blk_valid_out  out  1  delivered beat valid.
- blk_rdy_in  in  1  consumer ready.

## Operation
- **States and transitions:**
  - IDLE → ISSUE when start_in is high. On that transition, latch addr = base_addr_in with bits [4:0] cleared, remaining = num_blocks_in, and delivered = 0.
  - In ISSUE, issue bursts while remaining > 0. Go to DRAIN when remaining reaches 0.
  - DRAIN → IDLE when delivered equals the latched num_blocks.
- **Zero-length command:** num_blocks_in = 0 goes IDLE → DRAIN → IDLE, issues no request, and pulses done_out.
- **Burst size:** beats = min(MAX_BURST, remaining, (4096 − addr[11:0]) >> 5). A burst never crosses a 4 KB boundary.
- **Request fields:** rd_len_out = beats−1. On handshake: addr += beats<<5, remaining −= beats, credit += beats, rd_id_out increments mod 64.
- **Credit gate:** a request is presented only when credit + beats ≤ MAX_CREDIT. credit decrements once per beat accepted on blk (blk_valid_out && blk_rdy_in).
- **Same-cycle credit events:** an increment and a decrement in the same cycle net to the correct value; credit never wraps.
- **Delivery:** returned beats are delivered unchanged and in order. delivered increments once per blk handshake.
- **Stray data in IDLE:** rd_data_rdy_out = 1 and the beat is discarded, with no blk_valid_out. This drains beats still in flight after a reset.
- **start_in while busy:** ignored.

## Timing
- **Reset values:** busy_out 0, done_out 0, rd_info_valid_out 0, rd_id_out 0, rd_addr_out 0, rd_len_out 0, blk_valid_out 0, blk_data_out 0, rd_data_rdy_out 1. Counters are cleared and state is IDLE.
- **Request outputs are registered.** The first rd_info_valid_out appears the cycle after start_in is accepted.
- **Request hold:** while rd_info_valid_out && !rd_info_rdy_in, rd_id_out, rd_addr_out, rd_len_out and valid stay stable.
- **Back-to-back requests:** after a handshake, the next request may be valid in the following cycle, so valid can stay high across consecutive bursts.
- **Skid stage:** 2 entries. Latency is 1 cycle from rd_data_in acceptance to blk_valid_out. rd_data_rdy_out is registered and drops only when both entries are full. There are no bubbles at full throughput.
- **Completion:** done_out pulses the cycle after the last blk handshake. busy_out falls in the same cycle that done_out rises.
- **Reset mid-command:** everything returns to IDLE next cycle, both skid entries are flushed, and no done_out is produced.

## Structure
- **Package ref_fetch_pkg:** BLOCK_BYTES = 32, BOUNDARY_BYTES = 4096, ID_W = 6, and the state enum {IDLE, ISSUE, DRAIN}.
- **Sub-module ref_skid_buffer:** 2-entry, 256-bit valid/ready skid register.
- **Top level:** the FSM, burst-size computation and counters.

## Test plan
- **Single full burst:** base 0x1000, num_blocks 16, MAX_BURST 16 → one request (addr 0x1000, len 15, id 0), 16 beats out in order, done_out one cycle after the 16th blk handshake.
- **4 KB split:** base 0x1FC0, num_blocks 8 → requests (0x1FC0, len 1), then (0x2000, len 5).
- **Credit stall:** MAX_CREDIT 32, num_blocks 64, blk_rdy_in held 0 → exactly 2 bursts issued, then valid stays low. Releasing blk_rdy_in resumes issue.
- **Backpressure:** rd_info_rdy_in low for 5 cycles → fields stable throughout. Toggling blk_rdy_in at random → no beat lost or duplicated, and rd_id_out wraps from 63 to 0 after 64 bursts.
- **Zero and ignored commands:** num_blocks 0 → no request, done_out pulse. start_in while busy → ignored.
- **Reset mid-burst:** rst mid-burst, then stray rd_data_valid_in beats → beats accepted and dropped, blk_valid_out stays 0, no done_out.

Source files
------------

// File: rtl/ref_fetch_pkg.sv
// Shared constants, state encoding and burst sizing for the reference fetch scheduler.
package ref_fetch_pkg;

    localparam int unsigned BLOCK_BYTES    = 32;
    localparam int unsigned BLOCK_SHIFT    = 5;
    localparam int unsigned BOUNDARY_BYTES = 4096;
    localparam int unsigned ID_W           = 6;
    localparam int unsigned LEN_W          = 8;
    localparam int unsigned ADDR_W         = 32;
    localparam int unsigned DATA_W         = 256;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_e;

    // Beats in the next burst: capped by the burst limit, the blocks left and the 4 KB page.
    function automatic logic [31:0] burst_beats(input logic [11:0] addr_lo,
                                                input logic [31:0] remaining,
                                                input logic [31:0] max_burst);
        logic [12:0] room_bytes;
        logic [31:0] beats;
        room_bytes = 13'(BOUNDARY_BYTES) - {1'b0, addr_lo};
        beats      = 32'(room_bytes >> BLOCK_SHIFT);
        if (remaining < beats) beats = remaining;
        if (max_burst < beats) beats = max_burst;
        return beats;
    endfunction

endpackage

// File: rtl/ref_skid_buffer.sv
// Two-entry valid/ready skid register; both the output and the input ready are registered.
module ref_skid_buffer
    import ref_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_valid_i,
    output logic              in_rdy_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_valid_o,
    input  logic              out_rdy_i
);

    logic [1:0]        count_q, count_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;
    logic              out_valid_q, out_valid_d;
    logic              in_rdy_q, in_rdy_d;
    logic              push, pop;
    logic [1:0]        wr_slot;

    // Head always drives the output; a push lands in the first free slot after any pop.
    always_comb begin
        push    = in_valid_i && in_rdy_q;
        pop     = out_valid_q && out_rdy_i;
        head_d  = head_q;
        tail_d  = tail_q;
        wr_slot = count_q - 2'(pop);
        if (pop) head_d = tail_q;
        if (push) begin
            if (wr_slot == 2'd0) head_d = in_data_i;
            else                 tail_d = in_data_i;
        end
        count_d     = count_q + 2'(push) - 2'(pop);
        out_valid_d = (count_d != 2'd0);
        in_rdy_d    = (count_d != 2'd2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= 2'd0;
            head_q      <= '0;
            tail_q      <= '0;
            out_valid_q <= 1'b0;
            in_rdy_q    <= 1'b1;
        end else begin
            count_q     <= count_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            out_valid_q <= out_valid_d;
            in_rdy_q    <= in_rdy_d;
        end
    end

    assign in_rdy_o    = in_rdy_q;
    assign out_data_o  = head_q;
    assign out_valid_o = out_valid_q;

endmodule

// File: rtl/ref_fetch_scheduler.sv
// Splits a "fetch N blocks from A" command into credit-gated, 4 KB-safe AXI read bursts
// and returns the data beats in order through a skid stage.
module ref_fetch_scheduler
    import ref_fetch_pkg::*;
#(
    parameter int unsigned MAX_BURST  = 16,
    parameter int unsigned MAX_CREDIT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_in,
    input  logic [31:0]       base_addr_in,
    input  logic [31:0]       num_blocks_in,
    output logic              busy_out,
    output logic              done_out,
    output logic [ID_W-1:0]   rd_id_out,
    output logic [ADDR_W-1:0] rd_addr_out,
    output logic [LEN_W-1:0]  rd_len_out,
    output logic              rd_info_valid_out,
    input  logic              rd_info_rdy_in,
    input  logic [DATA_W-1:0] rd_data_in,
    input  logic              rd_data_valid_in,
    output logic              rd_data_rdy_out,
    output logic [DATA_W-1:0] blk_data_out,
    output logic              blk_valid_out,
    input  logic              blk_rdy_in
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       remaining_q, remaining_d;
    logic [31:0]       num_blocks_q, num_blocks_d;
    logic [31:0]       delivered_q, delivered_d;
    logic [31:0]       credit_q, credit_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              req_valid_q, req_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              req_hs, req_hold, blk_hs, blk_valid, skid_in_valid;
    logic [31:0]       cur_beats, next_beats;

    // Beats arriving in IDLE are strays from before a reset: accept and drop them.
    assign skid_in_valid = rd_data_valid_in && (state_q != IDLE);

    ref_skid_buffer u_skid (
        .clk        (clk),
        .rst        (rst),
        .in_data_i  (rd_data_in),
        .in_valid_i (skid_in_valid),
        .in_rdy_o   (rd_data_rdy_out),
        .out_data_o (blk_data_out),
        .out_valid_o(blk_valid),
        .out_rdy_i  (blk_rdy_in)
    );

    assign blk_hs = blk_valid && blk_rdy_in;

    always_comb begin
        req_hs       = req_valid_q && rd_info_rdy_in;
        req_hold     = req_valid_q && !rd_info_rdy_in;
        cur_beats    = 32'(len_q) + 32'd1;
        state_d      = state_q;
        addr_d       = addr_q;
        remaining_d  = remaining_q;
        num_blocks_d = num_blocks_q;
        delivered_d  = delivered_q + 32'(blk_hs);
        credit_d     = credit_q - 32'(blk_hs);
        id_d         = id_q;
        len_d        = len_q;
        req_valid_d  = 1'b0;
        busy_d       = busy_q;
        done_d       = 1'b0;
        next_beats   = '0;

        if (req_hs) begin
            addr_d      = addr_q + (cur_beats << BLOCK_SHIFT);
            remaining_d = remaining_q - cur_beats;
            credit_d    = credit_d + cur_beats;
            id_d        = id_q + ID_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (start_in) begin
                    addr_d       = base_addr_in & ~ADDR_W'(BLOCK_BYTES - 1);
                    remaining_d  = num_blocks_in;
                    num_blocks_d = num_blocks_in;
                    delivered_d  = '0;
                    busy_d       = 1'b1;
                    state_d      = (num_blocks_in == '0) ? DRAIN : ISSUE;
                end
            end
            ISSUE: begin
                if (remaining_d == '0) state_d = DRAIN;
            end
            DRAIN: begin
                if (delivered_d == num_blocks_q) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Next request is sized from post-handshake values so valid can stay high back to back.
        next_beats = burst_beats(addr_d[11:0], remaining_d, MAX_BURST);
        if (req_hold) begin
            req_valid_d = 1'b1;
        end else if (state_d == ISSUE && remaining_d != '0 &&
                     credit_d + next_beats <= MAX_CREDIT) begin
            req_valid_d = 1'b1;
            len_d       = LEN_W'(next_beats - 32'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            remaining_q  <= '0;
            num_blocks_q <= '0;
            delivered_q  <= '0;
            credit_q     <= '0;
            id_q         <= '0;
            len_q        <= '0;
            req_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            remaining_q  <= remaining_d;
            num_blocks_q <= num_blocks_d;
            delivered_q  <= delivered_d;
            credit_q     <= credit_d;
            id_q         <= id_d;
            len_q        <= len_d;
            req_valid_q  <= req_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign busy_out          = busy_q;
    assign done_out          = done_q;
    assign rd_id_out         = id_q;
    assign rd_addr_out       = addr_q;
    assign rd_len_out        = len_q;
    assign rd_info_valid_out = req_valid_q;
    assign blk_valid_out     = blk_valid;

endmodule

// File: tb/tb_ref_fetch_scheduler.sv
// Randomized bench for ref_fetch_scheduler: a queue-based model of bursts, beats and completion.
module tb_ref_fetch_scheduler;

    localparam int unsigned MAX_BURST  = 16;
    localparam int unsigned MAX_CREDIT = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_in;
    logic [31:0]  base_addr_in;
    logic [31:0]  num_blocks_in;
    logic         busy_out;
    logic         done_out;
    logic [5:0]   rd_id_out;
    logic [31:0]  rd_addr_out;
    logic [7:0]   rd_len_out;
    logic         rd_info_valid_out;
    logic         rd_info_rdy_in;
    logic [255:0] rd_data_in;
    logic         rd_data_valid_in;
    logic         rd_data_rdy_out;
    logic [255:0] blk_data_out;
    logic         blk_valid_out;
    logic         blk_rdy_in;

    always #5 clk = ~clk;

    ref_fetch_scheduler #(.MAX_BURST(MAX_BURST), .MAX_CREDIT(MAX_CREDIT)) dut (
        .clk              (clk),
        .rst              (rst),
        .start_in         (start_in),
        .base_addr_in     (base_addr_in),
        .num_blocks_in    (num_blocks_in),
        .busy_out         (busy_out),
        .done_out         (done_out),
        .rd_id_out        (rd_id_out),
        .rd_addr_out      (rd_addr_out),
        .rd_len_out       (rd_len_out),
        .rd_info_valid_out(rd_info_valid_out),
        .rd_info_rdy_in   (rd_info_rdy_in),
        .rd_data_in       (rd_data_in),
        .rd_data_valid_in (rd_data_valid_in),
        .rd_data_rdy_out  (rd_data_rdy_out),
        .blk_data_out     (blk_data_out),
        .blk_valid_out    (blk_valid_out),
        .blk_rdy_in       (blk_rdy_in)
    );

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } req_t;

    req_t         exp_req[$];
    logic [255:0] exp_data[$];
    int           checks = 0;
    int           errors = 0;
    int           pend_beats = 0;
    int           blk_left = 0;
    int           req_beats = 0;
    int           blk_beats = 0;
    int           bursts = 0;
    int           strays = 0;
    bit           exp_busy = 0;
    bit           exp_done = 0;
    bit           zpend = 0;
    bit           prev_hold = 0;
    bit           saw63 = 0;
    bit           saw_wrap = 0;
    logic [5:0]   exp_id = 6'd0;
    logic [31:0]  hold_addr;
    logic [7:0]   hold_len;
    logic [5:0]   hold_id;
    int           rinfo_mode = 0;
    int           blk_mode = 0;

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", nm, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chkd(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Expected burst list straight from the sizing rule.
    function automatic void plan(input logic [31:0] base, input logic [31:0] n);
        logic [31:0] a;
        logic [31:0] rem;
        logic [31:0] room;
        logic [31:0] b;
        a   = base & 32'hFFFF_FFE0;
        rem = n;
        while (rem > 0) begin
            room = (32'd4096 - (a & 32'h0000_0FFF)) / 32;
            b    = MAX_BURST;
            if (rem < b)  b = rem;
            if (room < b) b = room;
            exp_req.push_back('{addr: a, len: 8'(b - 1)});
            a   = a + b * 32;
            rem = rem - b;
        end
    endfunction

    function automatic logic pick(input int mode);
        if (mode == 0) return 1'b1;
        if (mode == 2) return 1'b0;
        return 1'($urandom_range(1));
    endfunction

    // One clock: drive inputs at the falling edge, then check outputs and advance the model.
    task automatic cyc(input bit st, input logic [31:0] base, input logic [31:0] n, input bit do_rst);
        bit done_next;
        bit busy_next;
        int b;
        @(negedge clk);
        rst              = do_rst;
        start_in         = st;
        base_addr_in     = base;
        num_blocks_in    = n;
        rd_info_rdy_in   = pick(rinfo_mode);
        blk_rdy_in       = pick(blk_mode);
        rd_data_valid_in = !do_rst && pend_beats > 0 && $urandom_range(3) != 0;
        for (int i = 0; i < 8; i++) rd_data_in[i*32 +: 32] = $urandom;
        if (do_rst) begin
            exp_req.delete();
            exp_data.delete();
            exp_busy  = 0;
            exp_done  = 0;
            zpend     = 0;
            prev_hold = 0;
            saw63     = 0;
            exp_id    = 6'd0;
            req_beats = 0;
            blk_beats = 0;
            blk_left  = 0;
            return;
        end

        chk1("busy", busy_out, exp_busy);
        chk1("done", done_out, exp_done);
        chk1("blk_valid", blk_valid_out, exp_data.size() > 0);
        chk1("rd_data_rdy", rd_data_rdy_out, exp_data.size() < 2);
        chk1("credit_bound", (req_beats - blk_beats) <= int'(MAX_CREDIT), 1'b1);
        if (prev_hold) begin
            chk1("hold_valid", rd_info_valid_out, 1'b1);
            chk32("hold_addr", rd_addr_out, hold_addr);
            chk32("hold_len", 32'(rd_len_out), 32'(hold_len));
            chk32("hold_id", 32'(rd_id_out), 32'(hold_id));
        end

        done_next = 0;
        busy_next = exp_busy;
        if (zpend) begin
            done_next = 1;
            zpend     = 0;
        end

        if (rd_info_valid_out) begin
            if (exp_req.size() == 0) begin
                chk1("req_unexpected", 1'b1, 1'b0);
            end else begin
                chk32("req_addr", rd_addr_out, exp_req[0].addr);
                chk32("req_len", 32'(rd_len_out), 32'(exp_req[0].len));
                chk32("req_id", 32'(rd_id_out), 32'(exp_id));
                if (rd_info_rdy_in) begin
                    b = int'(exp_req[0].len) + 1;
                    pend_beats += b;
                    req_beats  += b;
                    if (exp_id == 6'd63) saw63 = 1;
                    else if (exp_id == 6'd0 && saw63) saw_wrap = 1;
                    exp_id = exp_id + 6'd1;
                    bursts++;
                    void'(exp_req.pop_front());
                end
            end
        end
        prev_hold = rd_info_valid_out && !rd_info_rdy_in;
        hold_addr = rd_addr_out;
        hold_len  = rd_len_out;
        hold_id   = rd_id_out;

        if (blk_valid_out && blk_rdy_in && exp_data.size() > 0) begin
            chkd("blk_data", blk_data_out, exp_data.pop_front());
            blk_beats++;
            blk_left--;
            if (blk_left == 0) done_next = 1;
        end

        if (rd_data_valid_in && rd_data_rdy_out) begin
            pend_beats--;
            if (exp_busy) exp_data.push_back(rd_data_in);
            else          strays++;
        end

        if (st && !exp_busy) begin
            plan(base, n);
            blk_left  = int'(n);
            busy_next = 1;
            if (n == 0) zpend = 1;
        end
        if (done_next) busy_next = 0;
        exp_done = done_next;
        exp_busy = busy_next;
    endtask

    task automatic run_to_done(input string nm, input int budget);
        int c;
        c = 0;
        while ((exp_busy || pend_beats > 0) && c < budget) begin
            cyc(0, 32'd0, 32'd0, 0);
            c++;
        end
        chk1({nm, "_finished"}, c < budget, 1'b1);
    endtask

    initial begin
        rst = 1'b1; start_in = 1'b0; base_addr_in = '0; num_blocks_in = '0;
        rd_info_rdy_in = 1'b0; rd_data_in = '0; rd_data_valid_in = 1'b0; blk_rdy_in = 1'b0;

        cyc(0, 32'd0, 32'd0, 1);
        cyc(0, 32'd0, 32'd0, 1);
        cyc(0, 32'd0, 32'd0, 0);
        chk1("rst_valid", rd_info_valid_out, 1'b0);
        chk32("rst_id", 32'(rd_id_out), 32'd0);
        chk32("rst_addr", rd_addr_out, 32'd0);
        chk32("rst_len", 32'(rd_len_out), 32'd0);
        chk1("rst_blk_valid", blk_valid_out, 1'b0);
        chkd("rst_blk_data", blk_data_out, 256'd0);
        chk1("rst_data_rdy", rd_data_rdy_out, 1'b1);
        chk1("rst_busy", busy_out, 1'b0);

        // Single full burst
        cyc(1, 32'h0000_1000, 32'd16, 0);
        chk32("plan1_n", 32'(exp_req.size()), 32'd1);
        chk32("plan1_len", 32'(exp_req[0].len), 32'd15);
        cyc(0, 32'd0, 32'd0, 0);
        chk1("first_valid", rd_info_valid_out, 1'b1);
        chk32("first_addr", rd_addr_out, 32'h0000_1000);
        chk32("first_len", 32'(rd_len_out), 32'd15);
        chk32("first_id", 32'(rd_id_out), 32'd0);
        run_to_done("single", 500);
        chk32("single_beats", 32'(blk_beats), 32'd16);

        // 4 KB split
        cyc(1, 32'h0000_1FC0, 32'd8, 0);
        chk32("plan2_n", 32'(exp_req.size()), 32'd2);
        chk32("plan2_a0", exp_req[0].addr, 32'h0000_1FC0);
        chk32("plan2_l0", 32'(exp_req[0].len), 32'd1);
        chk32("plan2_a1", exp_req[1].addr, 32'h0000_2000);
        chk32("plan2_l1", 32'(exp_req[1].len), 32'd5);
        run_to_done("split", 500);

        // Credit stall
        blk_mode = 2;
        bursts   = 0;
        cyc(1, 32'h0000_4000, 32'd64, 0);
        repeat (60) cyc(0, 32'd0, 32'd0, 0);
        chk32("stall_bursts", 32'(bursts), 32'd2);
        chk1("stall_valid_low", rd_info_valid_out, 1'b0);
        blk_mode = 1;
        run_to_done("stall", 2000);
        chk32("stall_total", 32'(bursts), 32'd4);

        // Request backpressure
        rinfo_mode = 2;
        blk_mode   = 0;
        cyc(1, 32'h0000_8000, 32'd40, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 32'd0, 32'd0, 0);
            chk1("bp_valid", rd_info_valid_out, 1'b1);
            chk32("bp_addr", rd_addr_out, 32'h0000_8000);
            chk32("bp_id", 32'(rd_id_out), 32'd7);
        end
        rinfo_mode = 0;
        run_to_done("bp", 1000);

        // Zero-length and ignored start
        cyc(1, 32'h0000_0100, 32'd0, 0);
        chk32("zero_plan", 32'(exp_req.size()), 32'd0);
        run_to_done("zero", 20);
        cyc(1, 32'h0000_3000, 32'd20, 0);
        repeat (3) cyc(0, 32'd0, 32'd0, 0);
        cyc(1, 32'h0000_9000, 32'd5, 0);
        run_to_done("ignored", 1000);

        // Random commands under random backpressure
        rinfo_mode = 1;
        blk_mode   = 1;
        for (int k = 0; k < 10; k++) begin
            cyc(1, $urandom & 32'h0FFF_FFFF, 32'($urandom_range(120)), 0);
            run_to_done("rand", 5000);
        end
        cyc(1, $urandom & 32'h0FFF_FFFF, 32'd1100, 0);
        run_to_done("long", 30000);
        chk1("id_wrap", saw_wrap, 1'b1);

        // Reset mid-burst, then stray beats
        rinfo_mode = 0;
        cyc(1, 32'h0000_5000, 32'd48, 0);
        repeat (10) cyc(0, 32'd0, 32'd0, 0);
        cyc(0, 32'd0, 32'd0, 1);
        strays = 0;
        run_to_done("strays", 500);
        chk1("strays_seen", strays > 0, 1'b1);
        chk1("post_rst_blk_valid", blk_valid_out, 1'b0);

        // Recovery after reset
        cyc(1, 32'h0000_1000, 32'd16, 0);
        cyc(0, 32'd0, 32'd0, 0);
        chk32("recover_id", 32'(rd_id_out), 32'd0);
        run_to_done("recover", 1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
